// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller: FSM state, way index and performance counter width.
package cache_control_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } lc3b_cache_state;

    typedef logic        lc3b_cache_way;
    typedef logic [15:0] lc3b_perf_count;

    localparam lc3b_perf_count PERF_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cache_control_perf_counter.sv
// 16-bit saturating event counter with synchronous clear; used by cache_control
// for its performance counters.
module cache_perf_counter
    import cache_control_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic           en,
    output lc3b_perf_count count
);

    lc3b_perf_count count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != PERF_COUNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Hit/writeback/fill sequencer for the 2-way write-back L1 cache.
// Define CACHE_PERF_COUNTERS_EN to build the hit/miss/writeback counters.
//
// state     | meaning
// IDLE      | resolve request: hit completes now, miss picks victim
// WRITEBACK | dirty victim line being written to physical memory
// FILL      | missing line being read from physical memory and installed
module cache_control
    import cache_control_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic           hit0,
    input  logic           hit1,
    input  logic           dirty0,
    input  logic           dirty1,
    input  logic           lru,
    input  logic           pmem_resp,
    output logic           mem_resp,
    output logic           pmem_read,
    output logic           pmem_write,
    output logic           pmem_addr_sel,
    output logic           way_sel,
    output logic           load_data,
    output logic           data_src_sel,
    output logic           load_tag,
    output logic           load_valid,
    output logic           set_dirty,
    output logic           clear_dirty,
    output logic           load_lru,
    output logic           lru_in,
    output lc3b_perf_count hit_count,
    output lc3b_perf_count miss_count,
    output lc3b_perf_count wb_count
);

    lc3b_cache_state state_q, state_d;
    lc3b_cache_way   victim_way_q, victim_way_d;
    lc3b_cache_way   hit_way;
    logic            victim_dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            victim_way_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            victim_way_q <= victim_way_d;
        end
    end

    // Way 0 wins if the datapath ever reports both ways hitting.
    assign hit_way      = hit0 ? 1'b0 : 1'b1;
    assign victim_dirty = lru ? dirty1 : dirty0;

    always_comb begin
        state_d       = state_q;
        victim_way_d  = victim_way_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        data_src_sel  = 1'b0;
        load_tag      = 1'b0;
        load_valid    = 1'b0;
        set_dirty     = 1'b0;
        clear_dirty   = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;

        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        if (hit0 || hit1) begin
                            way_sel  = hit_way;
                            mem_resp = 1'b1;
                            load_lru = 1'b1;
                            lru_in   = ~hit_way;
                            if (mem_write) begin
                                load_data = 1'b1;
                                set_dirty = 1'b1;
                            end
                        end else begin
                            victim_way_d = lru;
                            state_d      = victim_dirty ? WRITEBACK : FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_sel       = victim_way_q;
                    if (pmem_resp) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    way_sel   = victim_way_q;
                    if (pmem_resp) begin
                        load_data    = 1'b1;
                        data_src_sel = 1'b1;
                        load_tag     = 1'b1;
                        load_valid   = 1'b1;
                        clear_dirty  = 1'b1;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_PERF_COUNTERS_EN
    logic           post_fill_q, post_fill_d;
    logic           hit_inc, miss_inc, wb_inc;
    lc3b_perf_count hit_cnt, miss_cnt, wb_cnt;

    // The re-check hit right after a fill belongs to the miss, not a new hit.
    always_comb begin
        post_fill_d = (state_q == FILL) && (state_d == IDLE);
        hit_inc     = mem_resp && !post_fill_q;
        miss_inc    = (state_q == IDLE) && (state_d != IDLE);
        wb_inc      = (state_q == WRITEBACK) && (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_fill_q <= 1'b0;
        end else begin
            post_fill_q <= post_fill_d;
        end
    end

    cache_perf_counter u_hit_counter (
        .clk   (clk),
        .clr   (rst),
        .en    (hit_inc),
        .count (hit_cnt)
    );

    cache_perf_counter u_miss_counter (
        .clk   (clk),
        .clr   (rst),
        .en    (miss_inc),
        .count (miss_cnt)
    );

    cache_perf_counter u_wb_counter (
        .clk   (clk),
        .clr   (rst),
        .en    (wb_inc),
        .count (wb_cnt)
    );

    assign hit_count  = rst ? '0 : hit_cnt;
    assign miss_count = rst ? '0 : miss_cnt;
    assign wb_count   = rst ? '0 : wb_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: the bench plays the cache datapath with
// a behavioural 2-way cache model and checks the controller against it.
module tb_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, hit0, hit1, dirty0, dirty1, lru, pmem_resp;
    logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel;
    logic        load_data, data_src_sel, load_tag, load_valid;
    logic        set_dirty, clear_dirty, load_lru, lru_in;
    logic [15:0] hit_count, miss_count, wb_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural cache: 4 sets x 2 ways, plus expected event counts.
    bit       valid_m [4][2];
    bit [3:0] tag_m   [4][2];
    bit       dirty_m [4][2];
    bit       lru_m   [4];
    int       exp_hit, exp_miss, exp_wb;
    bit       post_fill;

    always #5 clk = ~clk;

    cache_control dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .hit0          (hit0),
        .hit1          (hit1),
        .dirty0        (dirty0),
        .dirty1        (dirty1),
        .lru           (lru),
        .pmem_resp     (pmem_resp),
        .mem_resp      (mem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_addr_sel (pmem_addr_sel),
        .way_sel       (way_sel),
        .load_data     (load_data),
        .data_src_sel  (data_src_sel),
        .load_tag      (load_tag),
        .load_valid    (load_valid),
        .set_dirty     (set_dirty),
        .clear_dirty   (clear_dirty),
        .load_lru      (load_lru),
        .lru_in        (lru_in),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .wb_count      (wb_count)
    );

    function automatic logic [31:0] outs();
        return 32'({mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, load_data,
                    data_src_sel, load_tag, load_valid, set_dirty, clear_dirty, load_lru, lru_in});
    endfunction

    function automatic logic [31:0] ev(input bit resp, input bit prd, input bit pwr, input bit asel,
                                       input bit way, input bit ld, input bit src, input bit ltag,
                                       input bit lval, input bit sd, input bit cd, input bit llru,
                                       input bit lin);
        return 32'({resp, prd, pwr, asel, way, ld, src, ltag, lval, sd, cd, llru, lin});
    endfunction

    function automatic logic [31:0] cnt(input int v);
`ifdef CACHE_PERF_COUNTERS_EN
        return (v > 65535) ? 32'd65535 : 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_counters();
        chk("hit_count",  32'(hit_count),  cnt(exp_hit));
        chk("miss_count", 32'(miss_count), cnt(exp_miss));
        chk("wb_count",   32'(wb_count),   cnt(exp_wb));
    endtask

    task automatic drive(input int s, input bit [3:0] t, input bit rd, input bit wr, input bit pr);
        mem_read  = rd;
        mem_write = wr;
        hit0      = valid_m[s][0] && (tag_m[s][0] == t);
        hit1      = valid_m[s][1] && (tag_m[s][1] == t);
        dirty0    = dirty_m[s][0];
        dirty1    = dirty_m[s][1];
        lru       = lru_m[s];
        pmem_resp = pr;
    endtask

    // One CPU access to (set s, tag t); wl/fl are the writeback/fill latencies in cycles.
    task automatic do_access(input int s, input bit [3:0] t, input bit wr,
                             input int wl, input int fl, input bit drop);
        bit done = 1'b0;
        bit rd;
        bit h0, h1, w, v, last;
        while (!done) begin
            check_counters();
            rd = wr ? 1'($urandom % 2) : 1'b1;
            @(negedge clk);
            drive(s, t, rd, wr, 1'($urandom % 2));
            #1;
            h0 = valid_m[s][0] && (tag_m[s][0] == t);
            h1 = valid_m[s][1] && (tag_m[s][1] == t);
            if (h0 || h1) begin
                w = h0 ? 1'b0 : 1'b1;
                chk("hit_outputs", outs(), ev(1'b1, 0, 0, 0, w, wr, 0, 0, 0, wr, 0, 1'b1, !w));
                lru_m[s] = !w;
                if (wr) dirty_m[s][w] = 1'b1;
                if (!post_fill) exp_hit++;
                post_fill = 1'b0;
                done = 1'b1;
            end else begin
                v = lru_m[s];
                chk("miss_idle_outputs", outs(), 32'd0);
                exp_miss++;
                post_fill = 1'b0;
                if (dirty_m[s][v]) begin
                    for (int i = 1; i <= wl; i++) begin
                        @(negedge clk);
                        drive(s, t, drop ? 1'b0 : rd, drop ? 1'b0 : wr, i == wl);
                        #1;
                        chk("writeback_outputs", outs(), ev(0, 0, 1'b1, 1'b1, v, 0, 0, 0, 0, 0, 0, 0, 0));
                    end
                    exp_wb++;
                end
                for (int i = 1; i <= fl; i++) begin
                    @(negedge clk);
                    drive(s, t, drop ? 1'b0 : rd, drop ? 1'b0 : wr, i == fl);
                    #1;
                    last = (i == fl);
                    chk("fill_outputs", outs(), ev(0, 1'b1, 0, 0, v, last, last, last, last, 0, last, 0, 0));
                end
                valid_m[s][v] = 1'b1;
                tag_m[s][v]   = t;
                dirty_m[s][v] = 1'b0;
                post_fill     = 1'b1;
                if (drop) begin
                    @(negedge clk);
                    drive(s, t, 1'b0, 1'b0, 1'($urandom % 2));
                    #1;
                    chk("dropped_idle_outputs", outs(), 32'd0);
                    post_fill = 1'b0;
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int n_sat;
        for (int s = 0; s < 4; s++) begin
            lru_m[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                valid_m[s][w] = 1'b0;
                tag_m[s][w]   = 4'd0;
                dirty_m[s][w] = 1'b0;
            end
        end
        exp_hit = 0; exp_miss = 0; exp_wb = 0; post_fill = 1'b0;

        // Reset held with a live hit request on the inputs: everything must stay low.
        rst = 1'b1;
        mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1; hit1 = 1'b0;
        dirty0 = 1'b0; dirty1 = 1'b0; lru = 1'b0; pmem_resp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("reset_outputs", outs(), 32'd0);
        end
        check_counters();
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0;
        #1;
        chk("post_reset_outputs", outs(), 32'd0);

        // Both ways reporting a hit: way 0 takes priority.
        @(negedge clk);
        mem_read = 1'b1; hit0 = 1'b1; hit1 = 1'b1; lru = 1'b1;
        #1;
        chk("both_hit_outputs", outs(), ev(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1));
        exp_hit++;

        do_access(0, 4'd1, 1'b0, 1, 4, 1'b0);  // clean miss into way 0, fill after 4 cycles
        do_access(0, 4'd2, 1'b0, 1, 2, 1'b0);  // clean miss into way 1
        do_access(0, 4'd2, 1'b0, 1, 1, 1'b0);  // read hit on way 1
        do_access(0, 4'd2, 1'b1, 1, 1, 1'b0);  // write hit on way 1 (dirties it)
        do_access(0, 4'd1, 1'b0, 1, 1, 1'b0);  // read hit on way 0, lru -> way 1
        do_access(0, 4'd3, 1'b0, 3, 2, 1'b0);  // dirty miss: writeback then fill
        do_access(0, 4'd1, 1'b1, 1, 1, 1'b0);  // write hit on way 0
        check_counters();

        // Reset in the middle of a fill.
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
        dirty0 = 1'b0; dirty1 = 1'b1; lru = 1'b0; pmem_resp = 1'b0;
        #1;
        chk("rst_miss_outputs", outs(), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("rst_fill_outputs", outs(), ev(0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b1; hit1 = 1'b1;
        exp_hit = 0; exp_miss = 0; exp_wb = 0; post_fill = 1'b0;
        #1;
        chk("rst_held_outputs", outs(), 32'd0);
        check_counters();
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0; hit1 = 1'b0;
        #1;
        chk("after_rst_outputs", outs(), 32'd0);
        check_counters();
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        chk("idle_pmem_resp_ignored", outs(), 32'd0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk("idle_after_pmem_resp", outs(), 32'd0);

        do_access(2, 4'd7, 1'b1, 2, 3, 1'b1);  // request dropped mid-miss
        do_access(2, 4'd7, 1'b0, 1, 1, 1'b0);  // the installed line now hits

        for (int k = 0; k < 150; k++) begin
            do_access(int'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom % 2),
                      int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), ($urandom % 8) == 0);
        end
        check_counters();

        // Back-to-back hits, long enough to saturate the hit counter when it exists.
`ifdef CACHE_PERF_COUNTERS_EN
        n_sat = 65540;
`else
        n_sat = 20;
`endif
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; hit0 = 1'b1; hit1 = 1'b0; pmem_resp = 1'b0;
        repeat (n_sat) @(posedge clk);
        exp_hit += n_sat;
        @(negedge clk);
        #1;
        chk("sustained_hit_resp", 32'(mem_resp), 32'd1);
        check_counters();
        @(posedge clk);
        exp_hit++;
        @(negedge clk);
        #1;
        check_counters();

        mem_read = 1'b0; hit0 = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
